x448_scalar_loader: RTL and testbench

//   Upstream feeder for the base-point scalar multiplier. Accepts a 56-byte X448

---
 rtl/x448_scalar_loader_if.sv | 24 ++
 rtl/x448_scalar_loader.sv | 146 ++++++++++++++
 tb/tb_x448_scalar_loader.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/x448_scalar_loader_if.sv
// Byte-stream input and multiplier request bundle for the X448 scalar loader.
// slave: the loader itself; master: the stream source and the multiplier side.
interface x448_scalar_loader_if #(
    parameter int NBYTES = 56
);
    logic [7:0]          s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic [8*NBYTES-1:0] m_k;
    logic                m_affine;
    logic                m_req_valid;
    logic                m_req_busy;

    modport slave (
        input  s_data, s_valid, s_last, m_req_busy,
        output s_ready, m_k, m_affine, m_req_valid
    );

    modport master (
        output s_data, s_valid, s_last, m_req_busy,
        input  s_ready, m_k, m_affine, m_req_valid
    );
endinterface

// File: rtl/x448_scalar_loader.sv
// Assembles a little-endian byte stream into a 448-bit X448 scalar and issues it to the
// multiplier. Define X448_SCALAR_CLAMP_EN to apply RFC 7748 clamping to the issued K.
module x448_scalar_loader #(
    parameter int   NBYTES     = 56,
    parameter logic AFFINE_REQ = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    x448_scalar_loader_if.slave    bus,
    output logic                   busy,
    output logic                   err
);
    localparam int             KW       = 8 * NBYTES;
    localparam int             CW       = $clog2(NBYTES);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NBYTES - 1);
    localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_COLLECT   = 2'd0,
        S_DRAIN     = 2'd1,
        S_WAIT_FREE = 2'd2,
        S_ISSUE     = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [KW-1:0]   shreg_r, shreg_s, shift_s;
    logic [KW-1:0]   m_k_r, m_k_s;
    logic            s_ready_r, s_ready_s;
    logic            req_valid_r, req_valid_s;
    logic            err_r, err_s;
    logic            busy_r, busy_s;
    logic            xfer_s;

    function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
        logic [KW-1:0] c;
        c = k;
`ifdef X448_SCALAR_CLAMP_EN
        c[KW-1] = 1'b1;
        c[1:0]  = 2'b00;
`endif
        return c;
    endfunction

    assign xfer_s  = bus.s_valid & s_ready_r;
    assign shift_s = {bus.s_data, shreg_r[KW-1:8]};

    // Next-state and next-register values for the collect / drain / issue sequence
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        shreg_s     = shreg_r;
        m_k_s       = m_k_r;
        s_ready_s   = s_ready_r;
        req_valid_s = req_valid_r;
        err_s       = 1'b0;
        case (state_r)
            S_COLLECT: begin
                if (xfer_s) begin
                    shreg_s = shift_s;
                    if (cnt_r == LAST_IDX) begin
                        cnt_s = CNT_ZERO;
                        if (bus.s_last) begin
                            m_k_s     = clamp_k(shift_s);
                            s_ready_s = 1'b0;
                            state_s   = S_WAIT_FREE;
                        end else begin
                            err_s   = 1'b1;
                            state_s = S_DRAIN;
                        end
                    end else if (bus.s_last) begin
                        err_s = 1'b1;
                        cnt_s = CNT_ZERO;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            S_DRAIN: begin
                if (xfer_s && bus.s_last) begin
                    state_s = S_COLLECT;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            // Never raise a request while the previous job still reports busy
            S_WAIT_FREE: begin
                if (!bus.m_req_busy) begin
                    req_valid_s = 1'b1;
                    state_s     = S_ISSUE;
                end else begin
                    req_valid_s = 1'b0;
                end
            end
            S_ISSUE: begin
                if (bus.m_req_busy) begin
                    req_valid_s = 1'b0;
                    s_ready_s   = 1'b1;
                    state_s     = S_COLLECT;
                end else begin
                    req_valid_s = 1'b1;
                end
            end
            default: begin
                state_s     = S_COLLECT;
                cnt_s       = CNT_ZERO;
                s_ready_s   = 1'b1;
                req_valid_s = 1'b0;
            end
        endcase
        busy_s = (state_s != S_COLLECT);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_COLLECT;
            cnt_r       <= CNT_ZERO;
            shreg_r     <= {KW{1'b0}};
            m_k_r       <= {KW{1'b0}};
            s_ready_r   <= 1'b1;
            req_valid_r <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            shreg_r     <= shreg_s;
            m_k_r       <= m_k_s;
            s_ready_r   <= s_ready_s;
            req_valid_r <= req_valid_s;
            err_r       <= err_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.s_ready     = s_ready_r;
    assign bus.m_k         = m_k_r;
    assign bus.m_affine    = AFFINE_REQ;
    assign bus.m_req_valid = req_valid_r;
    assign busy            = busy_r;
    assign err             = err_r;
endmodule

// File: tb/tb_x448_scalar_loader.sv
// Scoreboard bench for x448_scalar_loader: frame drivers queue expected K / err cycles,
// a negedge monitor checks requests and error pulses, a behavioural multiplier answers.
module tb_x448_scalar_loader;
    localparam int NB = 56;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err;

    x448_scalar_loader_if #(.NBYTES(NB)) bus();

    x448_scalar_loader #(.NBYTES(NB), .AFFINE_REQ(1'b1)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int gap_max = 0;
    logic force_busy = 1'b0;
    logic hold_off   = 1'b0;

    logic [447:0] exp_k_q[$];
    int           exp_acc_q[$];
    int           exp_err_q[$];
    bit           busy_hist [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [447:0] act, input logic [447:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference scalar: bytes little-endian, optional RFC 7748 decodeScalar448 clamp
    function automatic logic [447:0] model_k(input logic [447:0] raw);
        logic [447:0] r;
        r = raw;
`ifdef X448_SCALAR_CLAMP_EN
        r[447]  = 1'b1;
        r[1:0]  = 2'b00;
`endif
        return r;
    endfunction

    function automatic logic [447:0] rand_k();
        logic [447:0] r;
        for (int i = 0; i < 14; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Behavioural multiplier: answers a request after 0..2 cycles, stays busy 1..15 cycles
    initial begin
        int delay;
        int run;
        delay = -1;
        run   = 0;
        bus.m_req_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (force_busy) begin
                bus.m_req_busy = 1'b1;
            end else if (run > 0) begin
                run--;
                bus.m_req_busy = 1'b1;
            end else begin
                bus.m_req_busy = 1'b0;
                if (!hold_off && bus.m_req_valid) begin
                    if (delay < 0) delay = $urandom_range(0, 2);
                    if (delay == 0) begin
                        bus.m_req_busy = 1'b1;
                        run   = $urandom_range(0, 14);
                        delay = -1;
                    end else begin
                        delay--;
                    end
                end else begin
                    delay = -1;
                end
            end
        end
    end

    // Monitor: checks err pulse timing and each request against the scoreboard
    logic         prev_valid = 1'b0;
    logic [447:0] cur_k = '0;
    always @(negedge clk) begin
        busy_hist[cyc % 65536] = bus.m_req_busy;
        if (!rst) begin
            if (err) begin
                if (exp_err_q.size() == 0) chk("err_unexpected", err, 1'b0);
                else chk("err_cycle", cyc, exp_err_q.pop_front());
            end
            if (bus.m_req_valid && !prev_valid) begin
                if (exp_k_q.size() == 0) begin
                    chk("req_unexpected", bus.m_req_valid, 1'b0);
                end else begin
                    int t;
                    logic [447:0] ek;
                    ek = exp_k_q.pop_front();
                    t  = exp_acc_q.pop_front() + 2;
                    while (t <= cyc && busy_hist[(t - 1) % 65536]) t++;
                    chk("req_latency", cyc, t);
                    chk("m_k", bus.m_k, ek);
                    chk("busy_ready_in_req", {busy, bus.s_ready}, 2'b10);
                    chk("m_affine", bus.m_affine, 1'b1);
                    cur_k = ek;
                end
            end else if (bus.m_req_valid) begin
                chk("m_k_stable", bus.m_k, cur_k);
            end
        end
        prev_valid = bus.m_req_valid;
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, gap_max)) begin
            bus.s_data = 8'($urandom);
            bus.s_last = 1'($urandom);
            sync();
        end
    endtask

    // Present one byte until accepted; acc = cycle whose closing edge took it
    task automatic send_byte(input logic [7:0] d, input logic l, output int acc);
        int n;
        n = 0;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.s_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_ready && n < 3000);
        if (!bus.s_ready) chk("s_ready_timeout", bus.s_ready, 1'b1);
        acc = cyc;
        sync();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'($urandom);
        bus.s_last  = 1'($urandom);
    endtask

    task automatic send_good(input logic [447:0] k);
        int acc;
        for (int i = 0; i < NB; i++) begin
            send_byte(k[8*i +: 8], (i == NB - 1), acc);
            if (i == NB - 1) begin
                exp_k_q.push_back(model_k(k));
                exp_acc_q.push_back(acc);
            end
            gap();
        end
    endtask

    task automatic send_short(input int n);
        int acc;
        for (int i = 0; i < n; i++) begin
            send_byte(8'($urandom), (i == n - 1), acc);
            if (i == n - 1) exp_err_q.push_back(acc + 1);
            gap();
        end
    endtask

    task automatic send_long(input int m);
        int acc;
        for (int i = 0; i < NB; i++) begin
            send_byte(8'($urandom), 1'b0, acc);
            if (i == NB - 1) exp_err_q.push_back(acc + 1);
            gap();
        end
        for (int j = 0; j < m; j++) begin
            send_byte(8'($urandom), (j == m - 1), acc);
            gap();
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 3000 && (exp_k_q.size() != 0 || exp_err_q.size() != 0 ||
                            bus.m_req_valid || bus.m_req_busy)) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", (n < 3000), 1'b1);
        sync();
    endtask

    initial begin
        logic [447:0] k;
        int kind;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 1'b1);
        chk("rst_m_req_valid", bus.m_req_valid, 1'b0);
        chk("rst_m_k", bus.m_k, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_m_affine", bus.m_affine, 1'b1);
        rst = 1'b0;
        sync();

        // Ascending bytes, then all-ones
        for (int i = 0; i < NB; i++) k[8*i +: 8] = 8'(i);
        send_good(k);
        wait_idle();
        k = {448{1'b1}};
        send_good(k);
        wait_idle();

        // Early s_last on byte 10, then a clean 0x11 scalar
        send_short(10);
        k = {56{8'h11}};
        send_good(k);
        wait_idle();

        // Missing s_last: three extra bytes drained, then a clean scalar
        send_long(3);
        send_good(rand_k());
        wait_idle();

        // Prior job still busy when the scalar completes
        @(negedge clk);
        force_busy = 1'b1;
        sync();
        send_good(rand_k());
        repeat (4) @(negedge clk);
        chk("wait_free_valid", bus.m_req_valid, 1'b0);
        chk("wait_free_busy_ready", {busy, bus.s_ready}, 2'b10);
        force_busy = 1'b0;
        wait_idle();

        // Reset while a request is outstanding
        @(negedge clk);
        hold_off = 1'b1;
        sync();
        send_good(rand_k());
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.m_req_valid && n < 200);
        end
        repeat (2) @(negedge clk);
        chk("issue_held", bus.m_req_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_m_req_valid", bus.m_req_valid, 1'b0);
        chk("abort_s_ready", bus.s_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_m_k", bus.m_k, '0);
        rst = 1'b0;
        hold_off = 1'b0;
        sync();
        send_good(rand_k());
        wait_idle();

        // Randomized mix of good, short and over-long frames with stream gaps
        gap_max = 2;
        repeat (24) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) send_good(rand_k());
            else if (kind == 2) send_short($urandom_range(2, 55));
            else send_long($urandom_range(1, 4));
        end
        wait_idle();
        chk("scoreboard_empty", exp_k_q.size() + exp_err_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        n_total++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end
endmodule
